// File: rtl/key_pulse_debouncer_pkg.sv
// Shared definitions for the pushbutton conditioning front end:
// FSM encoding, counter-width helper and board constants.
package key_pulse_debouncer_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } kpd_state_e;

  // Bits needed to hold the values 0 .. n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(n)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/key_pulse_debouncer_sync_debounce.sv
// Synchronises the raw active-low key and accepts a new level only after it
// has been steady for DEBOUNCE_CYCLES clocks.
module key_pulse_debouncer_sync_debounce
  import key_pulse_debouncer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic stable_o
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   raw_p;

  assign raw_p    = ~sync_q[SYNC_STAGES-1];
  assign stable_o = stable_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d    = '0;
    stable_d = stable_q;
    if (raw_p != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = raw_p;
      else                   cnt_d    = cnt_q + 1'b1;
    end
  end

  // The chain resets to all ones so a held key after reset looks like a fresh press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '1;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      // NOTE: state registers use <= so every flop samples pre-edge values.
      sync_q   <= {sync_q[SYNC_STAGES-2:0], key_n_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/key_pulse_debouncer.sv
// Pushbutton front end: debounced level, one-clock press/repeat strobe and
// one-clock release strobe for the manual-clock counter enable.
module key_pulse_debouncer
  import key_pulse_debouncer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_RATE     = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic pulse,
  output logic release_pulse
);

  localparam int unsigned RW =
    cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic       stable;
  kpd_state_e state_q;
  logic [RW-1:0] rep_cnt_q;

  key_pulse_debouncer_sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk     (clk),
    .reset   (reset),
    .key_n_i (key_n),
    .stable_o(stable)
  );

  // Release is tested first so it wins over a repeat falling due in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      rep_cnt_q     <= '0;
      pressed       <= 1'b0;
      pulse         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      pressed       <= stable;
      pulse         <= 1'b0;
      release_pulse <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (stable) begin
            pulse     <= 1'b1;
            rep_cnt_q <= '0;
            state_q   <= HELD;
          end
        end
        HELD: begin
          if (!stable) begin
            release_pulse <= 1'b1;
            state_q       <= IDLE;
          end else if (REPEAT_EN && rep_cnt_q == DELAY_LAST) begin
            pulse     <= 1'b1;
            rep_cnt_q <= '0;
            state_q   <= REPEAT;
          end else if (REPEAT_EN) begin
            rep_cnt_q <= rep_cnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (!stable) begin
            release_pulse <= 1'b1;
            state_q       <= IDLE;
          end else if (rep_cnt_q == RATE_LAST) begin
            pulse     <= 1'b1;
            rep_cnt_q <= '0;
          end else begin
            rep_cnt_q <= rep_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_pulse_debouncer.sv
// Scoreboard bench: a behavioural model predicts every cycle of both a
// repeating and a non-repeating instance; a monitor compares on each negedge.
module tb_key_pulse_debouncer;

  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int DELAY = 10;
  localparam int RATE  = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic key_n = 1'b1;
  logic pressed_r, pulse_r, rel_r;
  logic pressed_n, pulse_n, rel_n;

  key_pulse_debouncer #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1'b1),
    .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)
  ) dut (
    .clk(clk), .reset(reset), .key_n(key_n),
    .pressed(pressed_r), .pulse(pulse_r), .release_pulse(rel_r)
  );

  key_pulse_debouncer #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1'b0),
    .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)
  ) dut_nr (
    .clk(clk), .reset(reset), .key_n(key_n),
    .pressed(pressed_n), .pulse(pulse_n), .release_pulse(rel_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pressed;
    logic pulse;
    logic rel;
  } obs_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  obs_t exp_r[$];
  obs_t exp_n[$];
  int   edge_no = -1;
  int   e_since = 0;
  bit   ks[$];
  bit   rh[$];
  bit   st = 1'b0;
  bit   held = 1'b0;
  int   press_edge = 0;

  function automatic bit repeat_due(input int d, input bit en);
    return en && d >= DELAY && ((d - DELAY) % RATE) == 0;
  endfunction

  always @(posedge clk) begin
    obs_t er, en;
    bit   r, all_diff;
    edge_no++;
    if (reset) begin
      ks.delete();
      rh.delete();
      st      = 1'b0;
      held    = 1'b0;
      e_since = 0;
      exp_r.push_back('0);
      exp_n.push_back('0);
    end else begin
      // raw level seen before this edge: key sampled SYNC edges earlier, else released
      r = (e_since >= SYNC) ? !ks[e_since-SYNC] : 1'b0;
      rh.push_back(r);
      er = '0;
      er.pressed = st;
      en = er;
      if (!held && st) begin
        held = 1'b1;
        press_edge = e_since;
        er.pulse = 1'b1;
        en.pulse = 1'b1;
      end else if (held && !st) begin
        held = 1'b0;
        er.rel = 1'b1;
        en.rel = 1'b1;
      end else if (held) begin
        er.pulse = repeat_due(e_since - press_edge, 1'b1);
        en.pulse = repeat_due(e_since - press_edge, 1'b0);
      end
      // accept a new level once the last DEB raw values all disagree with it
      all_diff = (rh.size() >= DEB);
      if (all_diff)
        for (int i = rh.size() - DEB; i < rh.size(); i++)
          if (rh[i] == st) all_diff = 1'b0;
      if (all_diff) st = !st;
      ks.push_back(key_n);
      e_since++;
      exp_r.push_back(er);
      exp_n.push_back(en);
    end
  end

  // ---------------- monitor ----------------
  int p_log_r[$], r_log_r[$], p_log_n[$], r_log_n[$];

  always @(negedge clk) begin
    obs_t w;
    if (exp_r.size() > 0) begin
      w = exp_r.pop_front();
      check("rep_outputs", 32'({pressed_r, pulse_r, rel_r}), 32'(w));
    end
    if (exp_n.size() > 0) begin
      w = exp_n.pop_front();
      check("norep_outputs", 32'({pressed_n, pulse_n, rel_n}), 32'(w));
    end
    if (pulse_r) p_log_r.push_back(edge_no);
    if (rel_r)   r_log_r.push_back(edge_no);
    if (pulse_n) p_log_n.push_back(edge_no);
    if (rel_n)   r_log_n.push_back(edge_no);
  end

  // ---------------- stimulus ----------------
  int base = 0;

  task automatic begin_scn();
    p_log_r.delete();
    r_log_r.delete();
    p_log_n.delete();
    r_log_n.delete();
    base = edge_no + 1;
  endtask

  // Called at negedge+1; key level v is sampled on the next n posedges.
  task automatic hold_level(input bit v, input int n);
    key_n = v;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check_events(input string name, input int log_q[$], input int want_q[$]);
    check({name, "_count"}, log_q.size(), want_q.size());
    for (int i = 0; i < log_q.size() && i < want_q.size(); i++)
      check(name, log_q[i] - base, want_q[i]);
  endtask

  int none[$];
  int rep_list[$];
  int one6[$];

  initial begin
    bit lvl;
    int total, n;
    rep_list = '{6, 16, 19, 22, 25, 28, 31, 34};
    one6     = '{6};

    repeat (3) @(negedge clk);
    check("reset_state", 32'({pressed_r, pulse_r, rel_r, pressed_n, pulse_n, rel_n}), 32'd0);
    #1 reset = 1'b0;
    hold_level(1'b1, 5);

    // 1: clean press for 8 cycles
    begin_scn();
    hold_level(1'b0, 8);
    hold_level(1'b1, 20);
    check_events("s1_pulse", p_log_r, one6);
    check_events("s1_release", r_log_r, '{14});

    // 2: bounce with runs of 1-3 cycles
    begin_scn();
    lvl = 1'b0;
    total = 0;
    while (total < 40) begin
      n = $urandom_range(1, 3);
      hold_level(lvl, n);
      total += n;
      lvl = !lvl;
    end
    hold_level(1'b1, 20);
    check_events("s2_pulse", p_log_r, none);
    check_events("s2_release", r_log_r, none);

    // 3: long hold with auto-repeat
    begin_scn();
    hold_level(1'b0, 30);
    hold_level(1'b1, 15);
    check_events("s3_pulse", p_log_r, rep_list);
    check_events("s3_release", r_log_r, '{36});

    // 4: repeat disabled, 40-cycle hold
    begin_scn();
    hold_level(1'b0, 40);
    hold_level(1'b1, 15);
    check_events("s4_pulse_norep", p_log_n, one6);
    check_events("s4_release_norep", r_log_n, '{46});

    // 5: reset mid-repeat with key held
    begin_scn();
    hold_level(1'b0, 25);
    reset = 1'b1;
    #1;
    check("s5_async_reset", 32'({pressed_r, pulse_r, rel_r, pressed_n, pulse_n, rel_n}), 32'd0);
    repeat (5) @(negedge clk);
    #1 reset = 1'b0;
    begin_scn();
    hold_level(1'b0, 30);
    hold_level(1'b1, 15);
    check_events("s5_pulse", p_log_r, rep_list);
    check_events("s5_release", r_log_r, '{36});

    // 6: release coincides with a due repeat (edge 19)
    begin_scn();
    hold_level(1'b0, 13);
    hold_level(1'b1, 15);
    check_events("s6_pulse", p_log_r, '{6, 16});
    check_events("s6_release", r_log_r, '{19});

    // random presses, releases and glitches
    lvl = 1'b0;
    for (int s = 0; s < 40; s++) begin
      hold_level(lvl, $urandom_range(1, 25));
      lvl = !lvl;
    end
    hold_level(1'b1, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
